// File: rtl/byte_stream_pkg.sv
// ---------------------------------------------------------------------------
// byte_stream_pkg
// Shared definitions for the serial byte link. The serializer and the
// deserializer both import this package so the two ends agree on symbol
// width and bit order.
// ---------------------------------------------------------------------------
package byte_stream_pkg;

  // Width of one symbol on the link.
  localparam int DATA_W = 8;

  // Bit counter width for a symbol of w bits; never narrower than one bit.
  function automatic int bitcnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int BITCNT_W = bitcnt_w(DATA_W);

  // Bit-order selectors.
  localparam int MSB_FIRST = 0;
  localparam int LSB_FIRST = 1;

endpackage

// File: rtl/byte_serializer.sv
// ---------------------------------------------------------------------------
// byte_serializer
// Parallel-to-serial transmitter. Bytes arrive over a valid/ready handshake
// into a one-entry holding register and are then shifted out one bit per
// shift_enable cycle. The holding register lets the next byte be reloaded on
// the same edge that shifts the last bit of the current one, so a sustained
// stream has no idle bit between bytes.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   shift_enable bit strobe shared with the receiver
//   parallel_in  byte to send, sampled on accept (in_valid & in_ready)
//   in_valid     parallel_in is valid
//   in_ready     holding register is free
//   serial_out   current bit (IDLE_LEVEL when no byte is active)
//   bit_valid    serial_out carries a data bit
//   byte_start   one-cycle pulse after a byte is loaded into the shifter
//   byte_done    one-cycle pulse after the last bit of a byte was shifted
//   underrun     one-cycle pulse after a strobe arrived with the shifter idle
// ---------------------------------------------------------------------------
module byte_serializer
  import byte_stream_pkg::*;
#(
  parameter int   DATA_W     = byte_stream_pkg::DATA_W,
  parameter int   LSB_FIRST  = byte_stream_pkg::MSB_FIRST,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_enable,
  input  logic [DATA_W-1:0] parallel_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              serial_out,
  output logic              bit_valid,
  output logic              byte_start,
  output logic              byte_done,
  output logic              underrun
);

  localparam int CNT_W = bitcnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic LSB_MODE = (LSB_FIRST == byte_stream_pkg::LSB_FIRST);

  // Two-state machine; the state register is 'active'.
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  logic [DATA_W-1:0] hold_reg;
  logic              hold_valid;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic              active;
  logic              accept;
  logic              out_bit;

  assign accept   = in_valid && in_ready;
  assign in_ready = !hold_valid;

  // The shifter moves toward the output end and zero-fills behind it.
  assign shift_next = LSB_MODE ? {1'b0, shift_reg[DATA_W-1:1]}
                               : {shift_reg[DATA_W-2:0], 1'b0};
  assign out_bit    = LSB_MODE ? shift_reg[0] : shift_reg[DATA_W-1];

  // Outputs depend only on registered state.
  assign serial_out = (active == ST_SHIFT) ? out_bit : IDLE_LEVEL;
  assign bit_valid  = (active == ST_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_reg   <= '0;
      hold_valid <= 1'b0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      active     <= ST_IDLE;
      byte_start <= 1'b0;
      byte_done  <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      byte_start <= 1'b0;
      byte_done  <= 1'b0;
      underrun   <= 1'b0;

      // Accept only happens with hold_valid low, so it never collides with
      // the transfers below, which all require hold_valid high.
      if (accept) begin
        hold_reg   <= parallel_in;
        hold_valid <= 1'b1;
      end

      if (active == ST_IDLE) begin
        // The receiver sampled IDLE_LEVEL on this strobe; flag it even if a
        // load happens on the same edge.
        if (shift_enable) begin
          underrun <= 1'b1;
        end
        if (hold_valid) begin
          shift_reg  <= hold_reg;
          bit_cnt    <= '0;
          active     <= ST_SHIFT;
          hold_valid <= 1'b0;
          byte_start <= 1'b1;
        end
      end else if (shift_enable) begin
        if (bit_cnt == LAST_BIT) begin
          byte_done <= 1'b1;
          bit_cnt   <= '0;
          if (hold_valid) begin
            // Gapless reload: the next byte's first bit follows immediately.
            shift_reg  <= hold_reg;
            hold_valid <= 1'b0;
            byte_start <= 1'b1;
          end else begin
            shift_reg <= shift_next;
            active    <= ST_IDLE;
          end
        end else begin
          shift_reg <= shift_next;
          bit_cnt   <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_byte_serializer.sv
// ---------------------------------------------------------------------------
// tb_byte_serializer
// Directed bench for byte_serializer: single byte, back-to-back, gapped
// strobe, underrun, reset mid-byte and a loopback receiver.
// ---------------------------------------------------------------------------
module tb_byte_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       shift_enable;
  logic [7:0] parallel_in;
  logic       in_valid;
  logic       in_ready;
  logic       serial_out;
  logic       bit_valid;
  logic       byte_start;
  logic       byte_done;
  logic       underrun;

  int n_checks = 0;
  int n_pass   = 0;

  // Receiver model: collects MSB-first bits on strobes that carry data.
  logic [7:0] rx_sh  = 8'h00;
  int         rx_cnt = 0;
  logic [7:0] rx_q[$];
  int         under_cnt = 0;

  byte_serializer dut (
    .clk          (clk),
    .rst          (rst),
    .shift_enable (shift_enable),
    .parallel_in  (parallel_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .serial_out   (serial_out),
    .bit_valid    (bit_valid),
    .byte_start   (byte_start),
    .byte_done    (byte_done),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      rx_cnt = 0;
      rx_sh  = 8'h00;
    end else begin
      if (shift_enable && bit_valid) begin
        rx_sh = {rx_sh[6:0], serial_out};
        rx_cnt++;
        if (rx_cnt == 8) begin
          rx_q.push_back(rx_sh);
          rx_cnt = 0;
        end
      end
      if (underrun) under_cnt++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      tick;
      waited++;
    end
    check("send_ready", int'(in_ready), 1);
    in_valid    = 1'b1;
    parallel_in = b;
    tick;
    in_valid    = 1'b0;
    $display("send byte 0x%02h", b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  pat;
    logic [15:0] stream;
    logic [7:0]  lb [4];
    int base, u0, idx, ndone;
    logic acc;

    rst = 1'b1; shift_enable = 1'b0; in_valid = 1'b0; parallel_in = 8'h00;
    tick; tick;
    check("rst_in_ready",   int'(in_ready),   1);
    check("rst_serial",     int'(serial_out), 0);
    check("rst_bit_valid",  int'(bit_valid),  0);
    check("rst_byte_start", int'(byte_start), 0);
    check("rst_byte_done",  int'(byte_done),  0);
    check("rst_underrun",   int'(underrun),   0);
    rst = 1'b0;
    tick;
    u0 = under_cnt;

    // ---- single byte 0xA5 ----
    pat = 8'hA5;
    send_byte(pat);
    check("t1_hold_full", int'(in_ready),  0);
    check("t1_not_active", int'(bit_valid), 0);
    tick;
    check("t1_byte_start", int'(byte_start), 1);
    check("t1_ready_again", int'(in_ready),  1);
    shift_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t1_bit",   int'(serial_out), int'(pat[7-i]));
      check("t1_valid", int'(bit_valid),  1);
      check("t1_no_done", int'(byte_done), 0);
      tick;
    end
    check("t1_byte_done", int'(byte_done),  1);
    check("t1_idle_valid", int'(bit_valid), 0);
    check("t1_idle_level", int'(serial_out), 0);
    shift_enable = 1'b0;
    tick;
    check("t1_done_pulse", int'(byte_done), 0);

    // ---- back-to-back 0x3C, 0xF0 ----
    base = rx_q.size();
    send_byte(8'h3C);
    tick;
    check("t2_start_a", int'(byte_start), 1);
    shift_enable = 1'b1;
    in_valid = 1'b1;
    parallel_in = 8'hF0;
    stream = 16'h3CF0;
    for (int i = 0; i < 16; i++) begin
      check("t2_bit",   int'(serial_out), int'(stream[15-i]));
      check("t2_valid", int'(bit_valid),  1);
      if (i == 8) begin
        check("t2_done_a",  int'(byte_done),  1);
        check("t2_start_b", int'(byte_start), 1);
      end
      tick;
      if (i == 0) begin
        in_valid = 1'b0;
        check("t2_accepted", int'(in_ready), 0);
      end
    end
    check("t2_done_b", int'(byte_done), 1);
    check("t2_idle",   int'(bit_valid), 0);
    shift_enable = 1'b0;
    tick;
    check("t2_rx_count", rx_q.size() - base, 2);
    if (rx_q.size() - base == 2) begin
      check("t2_rx_a", int'(rx_q[base]),   8'h3C);
      check("t2_rx_b", int'(rx_q[base+1]), 8'hF0);
    end
    check("t12_no_underrun", under_cnt - u0, 0);

    // ---- gapped strobe 0x81 ----
    base = rx_q.size();
    pat = 8'h81;
    send_byte(pat);
    tick;
    for (int k = 0; k < 8; k++) begin
      check("t3_bit", int'(serial_out), int'(pat[7-k]));
      shift_enable = 1'b1;
      tick;
      shift_enable = 1'b0;
      if (k < 7) begin
        check("t3_shifted", int'(serial_out), int'(pat[6-k]));
        tick;
        check("t3_hold_valid", int'(bit_valid), 1);
      end
    end
    check("t3_done", int'(byte_done), 1);
    check("t3_idle", int'(bit_valid), 0);
    tick;
    check("t3_rx_count", rx_q.size() - base, 1);
    if (rx_q.size() - base == 1) check("t3_rx", int'(rx_q[base]), 8'h81);

    // ---- underrun ----
    u0 = under_cnt;
    shift_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("t4_underrun", int'(underrun),   1);
      check("t4_in_ready", int'(in_ready),   1);
      check("t4_idle",     int'(serial_out), 0);
      check("t4_invalid",  int'(bit_valid),  0);
    end
    shift_enable = 1'b0;
    tick;
    check("t4_underrun_clear", int'(underrun), 0);
    check("t4_underrun_count", under_cnt - u0, 3);

    // ---- reset mid-byte ----
    send_byte(8'hFF);
    tick;
    shift_enable = 1'b1;
    tick; tick; tick;
    check("t5_mid_byte", int'(bit_valid), 1);
    rst = 1'b1;
    #1;
    check("t5_rst_valid",  int'(bit_valid),  0);
    check("t5_rst_serial", int'(serial_out), 0);
    check("t5_rst_ready",  int'(in_ready),   1);
    check("t5_rst_start",  int'(byte_start), 0);
    shift_enable = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    check("t5_stay_idle", int'(bit_valid), 0);
    base = rx_q.size();
    pat = 8'h55;
    send_byte(pat);
    tick;
    shift_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t5_bit", int'(serial_out), int'(pat[7-i]));
      tick;
    end
    check("t5_done", int'(byte_done), 1);
    shift_enable = 1'b0;
    tick;
    check("t5_rx_count", rx_q.size() - base, 1);
    if (rx_q.size() - base == 1) check("t5_rx", int'(rx_q[base]), 8'h55);

    // ---- loopback 0x00, 0xFF, 0xA5, 0x5A ----
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'hA5; lb[3] = 8'h5A;
    base = rx_q.size();
    u0 = under_cnt;
    send_byte(lb[0]);
    tick;
    shift_enable = 1'b1;
    idx = 1;
    in_valid = 1'b1;
    parallel_in = lb[1];
    ndone = 0;
    for (int cyc = 0; cyc < 200 && ndone < 4; cyc++) begin
      acc = in_valid && in_ready;
      tick;
      if (byte_done) ndone++;
      if (acc) idx++;
      if (idx < 4) begin
        in_valid = 1'b1;
        parallel_in = lb[idx];
      end else begin
        in_valid = 1'b0;
      end
    end
    shift_enable = 1'b0;
    in_valid = 1'b0;
    tick; tick;
    check("t6_done_count", ndone, 4);
    check("t6_rx_count", rx_q.size() - base, 4);
    if (rx_q.size() - base == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t6_rx", int'(rx_q[base+i]), int'(lb[i]));
        $display("loopback byte %0d: 0x%02h", i, rx_q[base+i]);
      end
    end
    check("t6_no_underrun", under_cnt - u0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/byte_serializer.md
Name: byte_serializer

Overview:
Parallel-to-serial transmitter that pairs with the team's serial-to-parallel byte deserializer on the same bit stream. It accepts bytes over a valid/ready handshake into a one-entry holding register. It then shifts each byte out one bit per shift_enable cycle, MSB first, in the same framing the deserializer expects. The holding register lets back-to-back bytes stream with no idle bit between them.

Parameters:
DATA_W, 8, width of one symbol. The deserializer and all test values use 8.
LSB_FIRST, 0, bit order. 0 sends MSB first, which matches the deserializer; 1 sends LSB first.
IDLE_LEVEL, 0, value driven on serial_out when no byte is active.

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
shift_enable  input  1  bit strobe shared with the deserializer; one bit is transferred per cycle in which it is high
parallel_in  input  DATA_W  byte to transmit; sampled on accept
in_valid  input  1  parallel_in is valid
in_ready  output  1  holding register is free; accept = in_valid & in_ready
serial_out  output  1  current bit; a pure function of registered state
bit_valid  output  1  serial_out carries a data bit, i.e. the shifter is active
byte_start  output  1  one-cycle pulse, registered, when a byte is loaded into the shifter
byte_done  output  1  one-cycle pulse, registered, after the last bit of a byte has been shifted
underrun  output  1  one-cycle pulse, registered, when shift_enable was high while the shifter was idle

Behaviour:
- State:
  - hold_reg[DATA_W-1:0] and hold_valid
  - shift_reg[DATA_W-1:0], bit_cnt[$clog2(DATA_W)-1:0] and active
  - The machine has two states: IDLE (active=0) and SHIFT (active=1).
- Reset (asynchronous, any time, including mid-byte):
  - hold_valid=0, active=0, bit_cnt=0, shift_reg=0, hold_reg=0.
  - byte_start=0, byte_done=0, underrun=0.
  - Outputs during reset: in_ready=1, serial_out=IDLE_LEVEL, bit_valid=0.
  - A partially sent byte is discarded and is never resumed.
- Input handshake:
  - in_ready = !hold_valid.
  - On accept: hold_reg<=parallel_in and hold_valid<=1.
  - in_valid while in_ready=0 has no effect. The source must hold its data until accepted.
- serial_out:
  - When active: shift_reg[DATA_W-1] for MSB-first, shift_reg[0] for LSB-first.
  - When not active: IDLE_LEVEL.
  - bit_valid = active.
- Load, IDLE→SHIFT: when active=0 and hold_valid=1:
  - shift_reg<=hold_reg, bit_cnt<=0, active<=1, hold_valid<=0.
  - byte_start pulses on the next cycle.
  - A shift_enable in this same cycle is an underrun; the load still happens.
- Shift: when active=1 and shift_enable=1:
  - Shift shift_reg by one toward the output end, zero-filling.
  - bit_cnt increments.
- Last bit: a shift when bit_cnt==DATA_W-1.
  - byte_done pulses on the next cycle.
  - If hold_valid=1, reload in the same edge: shift_reg<=hold_reg, bit_cnt<=0, hold_valid<=0, active stays 1, byte_start also pulses. This is the gapless back-to-back case.
  - Otherwise active<=0 and bit_cnt<=0.
- Idle behaviour:
  - active=1 with shift_enable=0 holds all shift state; the bit on serial_out is held.
  - shift_enable=1 with active=0 sets underrun for one cycle. No other state change results; the receiver has sampled IDLE_LEVEL.
- Latency:
  - Accept at edge N, load at edge N+1.
  - The first bit is on serial_out after edge N+1.
  - The first bit can be sampled at edge N+2 at the earliest.
- Throughput: DATA_W shift_enable cycles per byte. A sustained stream needs the next byte accepted before the current byte's last shift.
- Simultaneous events:
  - An accept and a hold→shift transfer cannot coincide, because in_ready=0 whenever hold_valid=1.
  - in_ready rises the cycle after the transfer.

Decomposition:
- Shared package byte_stream_pkg holds:
  - DATA_W default 8
  - BITCNT_W = $clog2(DATA_W)
  - localparams MSB_FIRST=0 and LSB_FIRST=1
  - The deserializer imports the same package so both ends agree on width and order.
- Single module, no sub-module needed.
- The hold register and the shifter stay inline; together they are the skid buffer and are too small to split out.

Test Plan:
- Single byte: reset, accept 0xA5, shift_enable held high.
  - Required: byte_start the cycle after load; serial_out = 1,0,1,0,0,1,0,1 on consecutive edges; byte_done one cycle after the 8th shift; then serial_out=0 and bit_valid=0.
- Back-to-back: accept 0x3C, then 0xF0 while the first byte is shifting, shift_enable continuous.
  - Required: 16 consecutive valid bits 00111100 11110000 with no idle bit between them.
  - byte_done for the first byte and byte_start for the second pulse in the same cycle.
- Gapped strobe: accept 0x81 with shift_enable toggling 1,0,1,0,…
  - Required: each bit holds across the low cycles, and the 8 sampled bits equal 10000001.
- Underrun: shift_enable high with no byte pending.
  - Required: underrun pulses once per such cycle; in_ready=1; serial_out=IDLE_LEVEL.
- Reset mid-byte: accept 0xFF and shift 3 bits, assert rst, release, then accept 0x55.
  - Required: outputs return to reset values immediately, and only 01010101 is sent after release.
- Loopback: connect serial_out to the deserializer's serial_in with a shared shift_enable, and send 0x00, 0xFF, 0xA5, 0x5A back-to-back.
  - Required: the deserializer's byte-ready pulses 4 times with parallel outputs 0x00, 0xFF, 0xA5, 0x5A in order.
